pixel_write_queue: RTL

PIXEL_WRITE_QUEUE -- requirements
Module: pixel_write_queue

---
 rtl/pixel_pkg.sv | 36 +++
 rtl/pixel_fifo.sv | 56 +++++
 rtl/pixel_write_queue.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel write queue: screen geometry,
// framebuffer widths, controller state encoding and the FIFO entry layout.
package pixel_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;
  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int ENTRY_W  = ADDR_W + COLOUR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [COLOUR_W-1:0] colour;
  } entry_t;

  // Row-major framebuffer address; the 160-wide screen uses shift-add instead of a multiplier.
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y,
                                                   input int unsigned    width);
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] row;
    y_ext = ADDR_W'(y);
    if (width == 160) row = (y_ext << 7) + (y_ext << 5);
    else              row = y_ext * ADDR_W'(width);
    return row + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous DEPTH-entry FIFO of framebuffer writes with full/empty flags.
// Push while full and pop while empty are ignored; simultaneous push/pop is allowed.
import pixel_pkg::*;

module pixel_fifo #(
  parameter int DEPTH = 8
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  entry_t wr_entry_i,
  input  logic   pop_i,
  output entry_t head_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t           mem_q [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_entry_i;
  end

endmodule

// File: rtl/pixel_write_queue.sv
// Queues pixel plots into a FIFO and drains them as handshaked framebuffer writes,
// with a whole-screen clear. Optional range filtering under PIXEL_BOUNDS_CHECK_EN.
import pixel_pkg::*;

module pixel_write_queue #(
  parameter int DEPTH           = 8,
  parameter int X_SCREEN_PIXELS = SCREEN_W,
  parameter int Y_SCREEN_PIXELS = SCREEN_H
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [X_W-1:0]      iX,
  input  logic [Y_W-1:0]      iY,
  input  logic [COLOUR_W-1:0] iColour,
  input  logic                iPlot,
  output logic                oReady,
  input  logic                iClear,
  output logic [ADDR_W-1:0]   oAddr,
  output logic [COLOUR_W-1:0] oData,
  output logic                oWe,
  input  logic                iAck,
  output logic                oBusy,
  output logic [7:0]          oDropCount
);

  localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(X_SCREEN_PIXELS * Y_SCREEN_PIXELS - 1);

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] clr_q, clr_d;

  entry_t            wr_entry;
  entry_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              out_of_range;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

`ifdef PIXEL_BOUNDS_CHECK_EN
  logic [7:0] drop_q, drop_d;

  assign out_of_range = (32'(iX) >= 32'(X_SCREEN_PIXELS)) ||
                        (32'(iY) >= 32'(Y_SCREEN_PIXELS));

  // Only a plot that would otherwise have been accepted counts as a drop.
  always_comb begin
    drop_d = drop_q;
    if (iPlot && !fifo_full && out_of_range) drop_d = sat_inc(drop_q);
  end

  always_ff @(posedge clk) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end

  assign oDropCount = drop_q;
`else
  assign out_of_range = 1'b0;
  assign oDropCount   = 8'd0;
`endif

  assign wr_entry.addr   = pixel_addr(iX, iY, X_SCREEN_PIXELS);
  assign wr_entry.colour = iColour;

  assign push = iPlot && !fifo_full && !out_of_range;
  assign pop  = (state_q == ST_WRITE) && iAck;

  pixel_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .wr_entry_i (wr_entry),
    .pop_i      (pop),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign oReady = !fifo_full;
  assign oBusy  = !fifo_empty || pending_q || (state_q != ST_IDLE);

  // A clear request is remembered until IDLE hands it to CLEAR; requests during CLEAR are dropped.
  always_comb begin
    pending_d = pending_q;
    if (iClear && (state_q != ST_CLEAR)) pending_d = 1'b1;
    if ((state_q == ST_IDLE) && pending_q) pending_d = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    clr_d   = clr_q;
    oWe     = 1'b0;
    oAddr   = '0;
    oData   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (pending_q)        state_d = ST_CLEAR;
        else if (!fifo_empty) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        oWe   = 1'b1;
        oAddr = head.addr;
        oData = head.colour;
        if (iAck) state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        oWe   = 1'b1;
        oAddr = clr_q;
        if (iAck) begin
          if (clr_q == CLEAR_LAST) begin
            clr_d   = '0;
            state_d = ST_IDLE;
          end else begin
            clr_d = clr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b0;
      clr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      clr_q     <= clr_d;
    end
  end

endmodule
